slow_memory: RTL and testbench

SLOW_MEMORY -- requirements
Module: slow_memory

---
 rtl/slow_memory_pkg.sv | 16 +
 rtl/slow_memory.sv | 116 +++++++++++
 tb/tb_slow_memory.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_memory_pkg.sv
// Shared widths, defaults and FSM state encoding for the slow line memory.
package slow_memory_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned ADDR_W      = 28;
    localparam int unsigned DEF_LATENCY = 5;
    localparam int unsigned DEF_MEM_NUM = 256;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : slow_memory_pkg

// File: rtl/slow_memory.sv
// Fixed-latency 128-bit line memory: a request is latched, counted for
// LATENCY cycles, then completed with a one-cycle mem_ready pulse.
module slow_memory
    import slow_memory_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned MEM_NUM = DEF_MEM_NUM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);

    localparam int unsigned IDX_W = $clog2(MEM_NUM);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("slow_memory: LATENCY must be within 2..15");
    end

    logic [LINE_W-1:0] mem [MEM_NUM];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              ready_q;
    logic [LINE_W-1:0] rdata_q;
    logic              done_entry;
    logic              req;
    logic              addr_unused;

    assign req         = mem_read | mem_write;
    assign addr_unused = ^mem_addr[ADDR_W-1:IDX_W];

    // Next-state: accept in IDLE, count in BUSY (abort if request drops), one DONE cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        done_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    idx_d   = mem_addr[IDX_W-1:0];
                    wdata_d = mem_wdata;
                    wr_d    = mem_write;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LATENCY - 2)) begin
                        state_d    = DONE;
                        done_entry = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers and registered read data / ready pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= done_entry;
            if (done_entry && !wr_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Latched request payload; only meaningful while a transaction is open
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
    end

    // Line storage: written only on completion of a write, never by reset
    always_ff @(posedge clk) begin
        if (rst_n && done_entry && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

endmodule : slow_memory

// File: tb/tb_slow_memory.sv
// Self-checking bench for slow_memory: transaction-level model plus directed
// scenarios and randomized traffic with resets, drops and address churn.
module tb_slow_memory;
    import slow_memory_pkg::*;

    localparam int unsigned LAT = 5;
    localparam int unsigned NUM = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [27:0]       mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    always #5 clk = ~clk;

    slow_memory #(.LATENCY(LAT), .MEM_NUM(NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model state
    logic [127:0] m_mem [NUM];
    bit           m_open = 1'b0;
    bit           m_done = 1'b0;
    int           m_age  = 0;
    bit           m_wr   = 1'b0;
    int           m_idx  = 0;
    logic [127:0] m_wdata = '0;
    logic         exp_ready = 1'b0;
    logic [127:0] exp_rdata = '0;

    localparam logic [127:0] D_026 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] A_028 = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] B_028 = 128'hBBBB_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
    localparam logic [127:0] C_029 = 128'hC0C0_C0C0_1234_5678_9ABC_DEF0_0F0F_0F0F;
    localparam logic [127:0] E_029 = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
    localparam logic [127:0] F_030 = 128'hF00D_CAFE_BEEF_0107_0000_1111_2222_3333;
    localparam logic [127:0] G_031 = 128'h6666_0020_0020_0020_0020_0020_0020_0020;
    localparam logic [127:0] H_031 = 128'h7777_0021_0021_0021_0021_0021_0021_0021;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A request is served LAT cycles after acceptance (acceptance cycle is
    // cycle 1); ready lasts one cycle and the memory then rests one cycle.
    task automatic model_step();
        if (!rst_n) begin
            m_open    = 1'b0;
            m_done    = 1'b0;
            exp_ready = 1'b0;
            exp_rdata = '0;
        end else if (m_done) begin
            m_done    = 1'b0;
            exp_ready = 1'b0;
        end else if (m_open) begin
            exp_ready = 1'b0;
            if (!mem_read && !mem_write) begin
                m_open = 1'b0;
            end else begin
                m_age++;
                if (m_age == int'(LAT) - 1) begin
                    m_open    = 1'b0;
                    m_done    = 1'b1;
                    exp_ready = 1'b1;
                    if (m_wr) m_mem[m_idx] = m_wdata;
                    else      exp_rdata    = m_mem[m_idx];
                end
            end
        end else begin
            exp_ready = 1'b0;
            if (mem_read || mem_write) begin
                m_open  = 1'b1;
                m_age   = 0;
                m_wr    = mem_write;
                m_idx   = int'(mem_addr) % int'(NUM);
                m_wdata = mem_wdata;
            end
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees, then compare
    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        chk("ready", {127'd0, mem_ready}, {127'd0, exp_ready});
        chk("rdata", mem_rdata, exp_rdata);
    endtask

    // Hold a request until mem_ready (bounded), then release and idle one cycle
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data, output int cyc);
        bit seen;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = data;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: addr %h no ready within 40 cycles", addr);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    initial begin
        int cyc;
        int last;
        int nready;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset state
        tick();
        tick();
        chk("reset_ready", {127'd0, mem_ready}, 128'd0);
        chk("reset_rdata", mem_rdata, 128'd0);
        rst_n = 1'b1;
        tick();

        // Fill every line so the model knows the whole array
        for (int i = 0; i < int'(NUM); i++) begin
            txn(1'b0, 1'b1, 28'(i), {$urandom, $urandom, $urandom, $urandom}, cyc);
        end

        // Basic write then read, latency pinned to 5
        txn(1'b0, 1'b1, 28'h0000005, D_026, cyc);
        chk("write_latency", 128'(cyc), 128'd5);
        txn(1'b1, 1'b0, 28'h0000005, '0, cyc);
        chk("read_latency", 128'(cyc), 128'd5);
        chk("read_data_5", mem_rdata, D_026);

        // Held request: ready every 6 cycles
        mem_read = 1'b1;
        mem_addr = 28'h0000005;
        last = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (mem_ready) begin
                if (last >= 0) chk("held_period", 128'(k - last), 128'd6);
                else           chk("held_first", 128'(k), 128'd5);
                last = k;
            end
        end
        mem_read = 1'b0;
        tick();
        tick();

        // Drop write after 2 busy cycles: no ready, line keeps old value
        txn(1'b0, 1'b1, 28'h0000009, A_028, cyc);
        mem_write = 1'b1;
        mem_addr  = 28'h0000009;
        mem_wdata = B_028;
        nready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mem_ready) nready++;
        end
        mem_write = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_ready) nready++;
        end
        chk("abort_no_ready", 128'(nready), 128'd0);
        txn(1'b1, 1'b0, 28'h0000009, '0, cyc);
        chk("abort_old_data", mem_rdata, A_028);

        // Reset mid-write: ready/rdata cleared, target line untouched
        txn(1'b0, 1'b1, 28'h0000007, C_029, cyc);
        mem_write = 1'b1;
        mem_addr  = 28'h0000007;
        mem_wdata = E_029;
        tick();
        tick();
        tick();
        rst_n     = 1'b0;
        mem_write = 1'b0;
        tick();
        chk("rst_mid_ready", {127'd0, mem_ready}, 128'd0);
        chk("rst_mid_rdata", mem_rdata, 128'd0);
        rst_n = 1'b1;
        tick();
        txn(1'b1, 1'b0, 28'h0000007, '0, cyc);
        chk("rst_line_kept", mem_rdata, C_029);
        txn(1'b1, 1'b0, 28'h0000005, '0, cyc);
        chk("rst_other_kept", mem_rdata, D_026);

        // Both requests high is a write; upper address bits wrap
        txn(1'b1, 1'b1, 28'h0000107, F_030, cyc);
        chk("model_line7", m_mem[7], F_030);
        txn(1'b1, 1'b0, 28'h0000007, '0, cyc);
        chk("wrap_write_read", mem_rdata, F_030);

        // Address changes during busy are ignored
        txn(1'b0, 1'b1, 28'h0000020, G_031, cyc);
        txn(1'b0, 1'b1, 28'h0000021, H_031, cyc);
        mem_read = 1'b1;
        mem_addr = 28'h0000020;
        tick();
        mem_addr = 28'h0000021;
        for (int k = 0; k < 10 && !mem_ready; k++) tick();
        chk("latched_addr", mem_rdata, G_031);
        mem_read = 1'b0;
        tick();
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 9) == 0) begin
                mem_read  = 1'($urandom);
                mem_write = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) mem_addr = 28'($urandom_range(0, 511));
                else                           mem_addr = 28'($urandom);
            end
            mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_slow_memory
